// File: rtl/pipeline_adder_nsteps_if.sv
// Operand/result bundle for pipeline_adder_nsteps; the adder takes the slave side.
// Optional ovf member exists only when PIPE_ADDER_OVF_EN is defined.
interface pipeline_adder_nsteps_if #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
);
  logic [STAGES-1:0] stop;
  logic [STAGES-1:0] refresh;
  logic              validin;
  logic [WIDTH-1:0]  cin_a;
  logic [WIDTH-1:0]  cin_b;
  logic              c_in;
  logic              sub;
  logic              out_allow;
  logic              allowin;
  logic              validout;
  logic [WIDTH-1:0]  sum_out;
  logic              c_out;

`ifdef PIPE_ADDER_OVF_EN
  logic              ovf;

  modport master (
    output stop, refresh, validin, cin_a, cin_b, c_in, sub, out_allow,
    input  allowin, validout, sum_out, c_out, ovf
  );
  modport slave (
    input  stop, refresh, validin, cin_a, cin_b, c_in, sub, out_allow,
    output allowin, validout, sum_out, c_out, ovf
  );
`else
  modport master (
    output stop, refresh, validin, cin_a, cin_b, c_in, sub, out_allow,
    input  allowin, validout, sum_out, c_out
  );
  modport slave (
    input  stop, refresh, validin, cin_a, cin_b, c_in, sub, out_allow,
    output allowin, validout, sum_out, c_out
  );
`endif
endinterface

// File: rtl/pipeline_adder_nsteps.sv
// STAGES-deep chunked add/sub, one WIDTH/STAGES slice per stage, latency STAGES, 1 result/cycle.
// Per-stage stop/refresh; stalls push back combinationally via allowin. PIPE_ADDER_OVF_EN adds ovf.
module pipeline_adder_nsteps #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input logic                    clk,
  input logic                    rst,
  pipeline_adder_nsteps_if.slave bus
);
  localparam int CHUNK = WIDTH / STAGES;

  if (STAGES < 1 || STAGES > 16 || (WIDTH % STAGES) != 0) begin : g_bad_cfg
    $error("pipeline_adder_nsteps: need 1..16 stages and WIDTH divisible by STAGES");
  end

  logic [STAGES-1:0] valid;
  logic [STAGES:0]   allow;
  logic [STAGES-1:0] load;

  // allow[i]: stage i will have room at the coming edge; walks downstream to upstream
  always_comb begin
    allow = '0;
    allow[STAGES] = bus.out_allow;
    for (int i = STAGES - 1; i >= 0; i--) begin
      allow[i] = ~valid[i] | bus.refresh[i] | (~bus.stop[i] & allow[i+1]);
    end
  end

  always_comb begin
    load    = '0;
    load[0] = bus.validin & allow[0];
    for (int i = 1; i < STAGES; i++) begin
      load[i] = valid[i-1] & ~bus.stop[i-1] & ~bus.refresh[i-1] & allow[i];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] sa, sb, ss, sn;
    logic             sc;
    logic [CHUNK:0]   part;
    logic             v_r, c_r;
    logic [WIDTH-1:0] a_r, b_r, s_r;

    if (k == 0) begin : g_in
      assign sa = bus.cin_a;
      assign sb = bus.sub ? ~bus.cin_b : bus.cin_b;
      assign ss = '0;
      assign sc = bus.c_in ^ bus.sub;
    end else begin : g_link
      assign sa = g_stage[k-1].a_r;
      assign sb = g_stage[k-1].b_r;
      assign ss = g_stage[k-1].s_r;
      assign sc = g_stage[k-1].c_r;
    end

    // slice k is added while entering stage k, so the last stage holds the finished sum
    assign part = {1'b0, sa[k*CHUNK +: CHUNK]} + {1'b0, sb[k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, sc};

    always_comb begin
      sn = ss;
      sn[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_r <= 1'b0;
        a_r <= '0;
        b_r <= '0;
        s_r <= '0;
        c_r <= 1'b0;
      end else begin
        if (load[k]) begin
          v_r <= 1'b1;
        end else if (bus.refresh[k] || (!bus.stop[k] && allow[k+1])) begin
          v_r <= 1'b0;
        end
        if (load[k]) begin
          a_r <= sa;
          b_r <= sb;
          s_r <= sn;
          c_r <= part[CHUNK];
        end
      end
    end

    assign valid[k] = v_r;
  end

  assign bus.allowin  = allow[0];
  assign bus.validout = valid[STAGES-1] & ~bus.stop[STAGES-1] & ~bus.refresh[STAGES-1];
  assign bus.sum_out  = g_stage[STAGES-1].s_r;
  assign bus.c_out    = g_stage[STAGES-1].c_r;

  // operands ride to the last stage only for the overflow sign test
  logic unused_tail;
  assign unused_tail = ^{g_stage[STAGES-1].a_r, g_stage[STAGES-1].b_r};

`ifdef PIPE_ADDER_OVF_EN
  assign bus.ovf = (g_stage[STAGES-1].a_r[WIDTH-1] == g_stage[STAGES-1].b_r[WIDTH-1])
                 & (g_stage[STAGES-1].s_r[WIDTH-1] != g_stage[STAGES-1].a_r[WIDTH-1]);
`endif
endmodule

// File: tb/tb_pipeline_adder_nsteps.sv
// Scoreboarded bench: 32/4 instance for stream/stall/refresh/reset cases, 8/2 instance for small-width cases.
module tb_pipeline_adder_nsteps;
  localparam int W  = 32;
  localparam int S  = 4;
  localparam int W8 = 8;
  localparam int S8 = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipeline_adder_nsteps_if #(.WIDTH(W),  .STAGES(S))  bus ();
  pipeline_adder_nsteps_if #(.WIDTH(W8), .STAGES(S8)) bus8 ();

  pipeline_adder_nsteps #(.WIDTH(W),  .STAGES(S))  dut  (.clk(clk), .rst(rst), .bus(bus));
  pipeline_adder_nsteps #(.WIDTH(W8), .STAGES(S8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t q[$];
  exp_t q8[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic. Subtract means a - b - c_in; carry-out means no borrow.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                 input bit ci, input bit s, input int c, input bit lat);
    exp_t   r;
    longint ua, ub, tot, sa, sb, st, lim, mask;
    ua   = longint'(a);
    ub   = longint'(b);
    mask = (longint'(1) << w) - 1;
    tot  = s ? (ua - ub - longint'(ci)) : (ua + ub + longint'(ci));
    r.sum  = 32'(tot & mask);
    r.cout = s ? (tot >= 0) : (((tot >> w) & 1) != 0);
    sa  = (((ua >> (w - 1)) & 1) != 0) ? ua - (longint'(1) << w) : ua;
    sb  = (((ub >> (w - 1)) & 1) != 0) ? ub - (longint'(1) << w) : ub;
    st  = s ? (sa - sb - longint'(ci)) : (sa + sb + longint'(ci));
    lim = longint'(1) << (w - 1);
    r.ovf = (st >= lim) || (st < -lim);
    r.cyc = c;
    r.lat = lat;
    return r;
  endfunction

  // Drive one cycle of stimulus; chk >= 0 also checks allowin against it.
  task automatic drive(input bit v, input logic [31:0] a, input logic [31:0] b,
                       input bit ci, input bit s, input bit lat, input int chk);
    bus.validin = v;
    bus.cin_a   = a;
    bus.cin_b   = b;
    bus.c_in    = ci;
    bus.sub     = s;
    @(negedge clk);
    if (chk >= 0) check("allowin", 64'(bus.allowin), 64'(chk));
    if (v && bus.allowin && rst) q.push_back(model(W, a, b, ci, s, cyc, lat));
    @(posedge clk);
    #1;
  endtask

  task automatic rnd(input int chk);
    drive(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, chk);
  endtask

  task automatic drive8(input bit v, input logic [7:0] a, input logic [7:0] b,
                        input bit ci, input bit s, input bit lat);
    bus8.validin = v;
    bus8.cin_a   = a;
    bus8.cin_b   = b;
    bus8.c_in    = ci;
    bus8.sub     = s;
    @(negedge clk);
    if (v && bus8.allowin && rst) q8.push_back(model(W8, {24'd0, a}, {24'd0, b}, ci, s, cyc, lat));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    bus.validin  = 1'b0;
    bus8.validin = 1'b0;
    while ((q.size() > 0 || q8.size() > 0) && n < 60) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_q", 64'(q.size()), 64'd0);
    check("drain_q8", 64'(q8.size()), 64'd0);
  endtask

  // Monitor for the 32-bit instance, including output stability while stalled.
  exp_t        e;
  bit          held = 1'b0;
  logic [31:0] held_sum;
  logic        held_c;
  always @(negedge clk) begin
    if (!rst) begin
      held = 1'b0;
    end else if (bus.validout) begin
      if (held) begin
        check("hold_sum", 64'(bus.sum_out), 64'(held_sum));
        check("hold_cout", 64'(bus.c_out), 64'(held_c));
      end
      if (bus.out_allow) begin
        held = 1'b0;
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got 0x%0h, expected no result", bus.sum_out);
        end else begin
          e = q.pop_front();
          check("sum", 64'(bus.sum_out), 64'(e.sum));
          check("cout", 64'(bus.c_out), 64'(e.cout));
`ifdef PIPE_ADDER_OVF_EN
          check("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
          if (e.lat) check("latency", 64'(cyc - e.cyc), 64'(S));
        end
      end else begin
        held     = 1'b1;
        held_sum = bus.sum_out;
        held_c   = bus.c_out;
      end
    end else begin
      held = 1'b0;
    end
  end

  exp_t e8;
  always @(negedge clk) begin
    if (rst && bus8.validout && bus8.out_allow) begin
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out8: got 0x%0h, expected no result", bus8.sum_out);
      end else begin
        e8 = q8.pop_front();
        check("sum8", 64'(bus8.sum_out), 64'(e8.sum));
        check("cout8", 64'(bus8.c_out), 64'(e8.cout));
`ifdef PIPE_ADDER_OVF_EN
        check("ovf8", 64'(bus8.ovf), 64'(e8.ovf));
`endif
        if (e8.lat) check("latency8", 64'(cyc - e8.cyc), 64'(S8));
      end
    end
  end

  initial begin
    bus.stop = '0;  bus.refresh = '0;  bus.validin = 1'b0;  bus.out_allow = 1'b1;
    bus.cin_a = '0; bus.cin_b = '0;    bus.c_in = 1'b0;     bus.sub = 1'b0;
    bus8.stop = '0; bus8.refresh = '0; bus8.validin = 1'b0; bus8.out_allow = 1'b1;
    bus8.cin_a = '0; bus8.cin_b = '0;  bus8.c_in = 1'b0;    bus8.sub = 1'b0;

    rst = 1'b0;
    #12;
    check("rst_validout", 64'(bus.validout), 64'd0);
    check("rst_sum", 64'(bus.sum_out), 64'd0);
    check("rst_cout", 64'(bus.c_out), 64'd0);
    check("rst_allowin", 64'(bus.allowin), 64'd1);
    check("rst_validout8", 64'(bus8.validout), 64'd0);
`ifdef PIPE_ADDER_OVF_EN
    check("rst_ovf", 64'(bus.ovf), 64'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b1;

    // directed arithmetic corners, latency-checked
    drive(1'b1, 32'd5, 32'd7, 1'b0, 1'b0, 1'b1, 1);
    repeat (6) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, -1);
    drive(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 1);
    drive(1'b1, 32'd3, 32'd5, 1'b0, 1'b1, 1'b1, 1);
    drive(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 1);
    drive(1'b1, 32'd0, 32'd0, 1'b1, 1'b1, 1'b1, 1);
    drive(1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1, 1);
    drive(1'b1, 32'h00FF_00FF, 32'h0001_FF01, 1'b1, 1'b0, 1'b1, 1);
    repeat (6) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, -1);

    // stall stage 1 for two cycles in a full stream
    repeat (10) rnd(-1);
    bus.stop = 4'b0010;
    repeat (2) rnd(0);
    bus.stop = 4'b0000;
    repeat (8) rnd(1);

    // flush stage 2: the pair issued three cycles ago is discarded
    bus.refresh = 4'b0100;
    for (int i = 0; i < q.size(); i++) begin
      if (q[i].cyc == cyc - 3) begin
        q.delete(i);
        break;
      end
    end
    rnd(1);
    bus.refresh = 4'b0000;
    repeat (6) rnd(1);

    // downstream refuses for five cycles with a full pipe
    bus.out_allow = 1'b0;
    repeat (5) rnd(0);
    bus.out_allow = 1'b1;
    repeat (6) rnd(-1);

    // random stalls and back-pressure
    for (int i = 0; i < 60; i++) begin
      bus.stop      = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      bus.out_allow = ($urandom_range(0, 3) != 0);
      drive(1'($urandom_range(0, 1)), $urandom, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, -1);
    end
    bus.stop      = 4'b0000;
    bus.out_allow = 1'b1;

    // reset mid-stream, then immediate reissue
    repeat (5) rnd(-1);
    rst = 1'b0;
    #1;
    check("midrst_validout", 64'(bus.validout), 64'd0);
    check("midrst_sum", 64'(bus.sum_out), 64'd0);
    check("midrst_cout", 64'(bus.c_out), 64'd0);
    bus.validin = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 32'd5, 32'd7, 1'b0, 1'b0, 1'b1, 1);
    drain();

    // narrow two-stage instance
    drive8(1'b1, 8'd5, 8'd7, 1'b0, 1'b0, 1'b1);
    drive8(1'b1, 8'hFF, 8'd1, 1'b0, 1'b0, 1'b1);
    drive8(1'b1, 8'd3, 8'd5, 1'b0, 1'b1, 1'b1);
    drive8(1'b1, 8'h7F, 8'd1, 1'b0, 1'b0, 1'b1);
    drive8(1'b1, 8'h80, 8'd1, 1'b0, 1'b1, 1'b1);
    drive8(1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      drive8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
